dispatch_queue: RTL and testbench
=================================

Name: dispatch_queue

Overview:
- Multi-lane in-order instruction buffer directly upstream of reg_station.
- Absorbs up to INPUT_ROWS decoded instructions per cycle from decode.
- Releases up to INPUT_ROWS per cycle into the station's new_* inputs, limited by the station's free-slot count.
- Decouples decode from station back-pressure and keeps program order.

Parameters:
- SIZE, 32, data/immediate width
- REG_NUM, 8, architectural register count; register index width is $clog2(REG_NUM)
- ALUOP_BITS, 3, ALU opcode width
- INPUT_ROWS, 2, lanes per cycle on both sides
- DEPTH, 8, queue entries; power of 2, >= 2*INPUT_ROWS

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous queue clear (mispredict)
- in_valid  in  [INPUT_ROWS-1:0]  per-lane push request
- in_ALUOp  in  [INPUT_ROWS-1:0][ALUOP_BITS-1:0]  opcode per lane
- in_src_reg1, in_src_reg2  in  [INPUT_ROWS-1:0][$clog2(REG_NUM)-1:0]  source regs
- in_use_imm  in  [INPUT_ROWS-1:0]  immediate select
- in_imm  in  [INPUT_ROWS-1:0][SIZE-1:0]  immediate
- in_dest_reg1  in  [INPUT_ROWS-1:0][$clog2(REG_NUM)-1:0]  destination reg
- in_ready  out  1  queue accepts a full lane group this cycle
- rs_free  in  [$clog2(INPUT_ROWS+1)-1:0]  instructions the station takes this cycle
- new_ALUOp, new_src_reg1, new_src_reg2, new_use_imm, new_imm, new_dest_reg1  out  same widths as in_*  to station
- new_valid  out  [INPUT_ROWS-1:0]  per-lane valid to station
- count  out  [$clog2(DEPTH+1)-1:0]  current occupancy

Behaviour:
- State: DEPTH entry array, head and tail pointers, count register.
- Reset values: count=0, head=0, tail=0, new_valid=0, all new_* data lanes 0.
- in_ready = (DEPTH - count) >= INPUT_ROWS. Combinational from registered count only, never from the same-cycle pop.
- Push:
  - When in_ready=1, valid lanes are written at tail in lane order, lane 0 first.
  - Gaps are compacted: in_valid=2'b10 writes lane 1 into slot tail.
  - tail advances by popcount(in_valid), modulo DEPTH.
- Push with in_ready=0: whole group dropped, no partial write; upstream must hold.
- Pop:
  - npop = min(count, rs_free, INPUT_ROWS).
  - new_valid is a thermometer of npop: lanes 0..npop-1 set.
  - Lane k carries entry head+k (mod DEPTH); lanes >= npop drive 0 on all data fields.
  - Outputs are combinational from stored entries and registered count.
  - Head advances by npop at the clock edge.
- Latency: an instruction pushed at edge N is visible on new_* no earlier than the cycle after edge N. No same-cycle bypass.
- Simultaneous push and pop: both apply; count_next = count + pushed - npop.
- Pointer wrap: modulo DEPTH. A group straddling the last index wraps to index 0 inside one cycle, in both push and pop.
- Full (count=DEPTH): in_ready=0; pop still proceeds.
- Empty (count=0): new_valid=0 regardless of rs_free.
- Priority: rst > flush > push/pop.
  - flush clears count, head and tail; any same-cycle push and pop are discarded.
  - Same-cycle new_valid is still driven combinationally, so the station must also ignore it on flush.
- Reset mid-operation behaves the same as flush plus clearing the optional counters.

Optional Feature:
- Macro: DISPATCH_QUEUE_STATS_EN
- Defined: adds outputs stall_cycles [31:0] and drop_count [31:0].
  - stall_cycles increments each cycle with count>0 and rs_free=0.
  - drop_count increments by popcount(in_valid) when in_valid!=0 and in_ready=0.
  - Both cleared by rst only (not by flush); saturate at all-ones.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, new_valid=00, in_ready=1, all new_* lanes 0.
- Single push, drain: in_valid=01 with ALUOp=3'b101, imm=0; rs_free=2 -> next cycle new_valid=01, new_ALUOp[0]=3'b101; following cycle count=0.
- Compaction: in_valid=10 with dest_reg1=3, rs_free=0, then rs_free=1 -> new_valid=01, new_dest_reg1[0]=3.
- Fill and back-pressure: rs_free=0, push 2 per cycle for 4 cycles -> count=8, in_ready=0. A fifth push is dropped (count stays 8; drop_count=2 with the macro). Then rs_free=2 -> 2 pops per cycle in push order.
- Wrap-around: 7 pushes and 7 pops to move head/tail to 7, then push 2 with imm=10 and 11 -> entries at indices 7 and 0. Popped with rs_free=2 in order 10, 11.
- Flush with simultaneous traffic: count=4, flush=1 with in_valid=11 and rs_free=2 -> next cycle count=0, new_valid=00, head=tail=0; no entry written.

Source files
------------

// File: rtl/dispatch_queue_if.sv
// Decode-side push lanes and station-side dispatch lanes of dispatch_queue.
// slave is the queue's view; master is the view of the surrounding pipeline.
interface dispatch_queue_if #(
  parameter int SIZE       = 32,
  parameter int REG_NUM    = 8,
  parameter int ALUOP_BITS = 3,
  parameter int INPUT_ROWS = 2,
  parameter int DEPTH      = 8
);
  localparam int REG_W   = $clog2(REG_NUM);
  localparam int FREE_W  = $clog2(INPUT_ROWS + 1);
  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic [INPUT_ROWS-1:0]                 in_valid;
  logic [INPUT_ROWS-1:0][ALUOP_BITS-1:0] in_ALUOp;
  logic [INPUT_ROWS-1:0][REG_W-1:0]      in_src_reg1;
  logic [INPUT_ROWS-1:0][REG_W-1:0]      in_src_reg2;
  logic [INPUT_ROWS-1:0]                 in_use_imm;
  logic [INPUT_ROWS-1:0][SIZE-1:0]       in_imm;
  logic [INPUT_ROWS-1:0][REG_W-1:0]      in_dest_reg1;
  logic                                  in_ready;

  logic [FREE_W-1:0]                     rs_free;
  logic [INPUT_ROWS-1:0]                 new_valid;
  logic [INPUT_ROWS-1:0][ALUOP_BITS-1:0] new_ALUOp;
  logic [INPUT_ROWS-1:0][REG_W-1:0]      new_src_reg1;
  logic [INPUT_ROWS-1:0][REG_W-1:0]      new_src_reg2;
  logic [INPUT_ROWS-1:0]                 new_use_imm;
  logic [INPUT_ROWS-1:0][SIZE-1:0]       new_imm;
  logic [INPUT_ROWS-1:0][REG_W-1:0]      new_dest_reg1;
  logic [COUNT_W-1:0]                    count;

  modport slave (
    input  in_valid, in_ALUOp, in_src_reg1, in_src_reg2, in_use_imm, in_imm, in_dest_reg1,
    input  rs_free,
    output in_ready, new_valid, new_ALUOp, new_src_reg1, new_src_reg2, new_use_imm,
    output new_imm, new_dest_reg1, count
  );

  modport master (
    output in_valid, in_ALUOp, in_src_reg1, in_src_reg2, in_use_imm, in_imm, in_dest_reg1,
    output rs_free,
    input  in_ready, new_valid, new_ALUOp, new_src_reg1, new_src_reg2, new_use_imm,
    input  new_imm, new_dest_reg1, count
  );
endinterface

// File: rtl/dispatch_queue.sv
// Multi-lane in-order buffer between decode and reg_station (compacting push, thermometer pop).
// Define DISPATCH_QUEUE_STATS_EN to add the stall_cycles / drop_count counters.
module dispatch_queue #(
  parameter int SIZE       = 32,
  parameter int REG_NUM    = 8,
  parameter int ALUOP_BITS = 3,
  parameter int INPUT_ROWS = 2,
  parameter int DEPTH      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
`ifdef DISPATCH_QUEUE_STATS_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       drop_count,
`endif
  dispatch_queue_if.slave   q
);
  localparam int REG_W   = $clog2(REG_NUM);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ALUOP_BITS-1:0] alu_op;
    logic [REG_W-1:0]      src_reg1;
    logic [REG_W-1:0]      src_reg2;
    logic                  use_imm;
    logic [SIZE-1:0]       imm;
    logic [REG_W-1:0]      dest_reg1;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [COUNT_W-1:0] count_q;

  logic               push_ok;
  logic [COUNT_W-1:0] nvalid;
  logic [COUNT_W-1:0] npush;
  logic [COUNT_W-1:0] npop;
  logic [PTR_W-1:0]   wr_idx [INPUT_ROWS];

  // Readiness looks only at the registered count so decode never sees a pop-dependent path.
  assign q.in_ready = (COUNT_W'(DEPTH) - count_q) >= COUNT_W'(INPUT_ROWS);
  assign push_ok    = q.in_ready && !flush && !rst;
  assign npush      = push_ok ? nvalid : '0;
  assign q.count    = count_q;

  // NOTE: blocking '=' here is intentional; nvalid is a running sum that each lane reads before adding itself.
  always_comb begin
    nvalid = '0;
    for (int i = 0; i < INPUT_ROWS; i++) begin
      wr_idx[i] = tail + PTR_W'(nvalid);
      if (q.in_valid[i]) nvalid = nvalid + 1'b1;
    end
  end

  always_comb begin
    npop = count_q;
    if (COUNT_W'(q.rs_free) < npop)   npop = COUNT_W'(q.rs_free);
    if (COUNT_W'(INPUT_ROWS) < npop)  npop = COUNT_W'(INPUT_ROWS);
  end

  // Lanes past npop are forced to zero so the station never sees stale entries.
  always_comb begin
    q.new_valid     = '0;
    q.new_ALUOp     = '0;
    q.new_src_reg1  = '0;
    q.new_src_reg2  = '0;
    q.new_use_imm   = '0;
    q.new_imm       = '0;
    q.new_dest_reg1 = '0;
    for (int k = 0; k < INPUT_ROWS; k++) begin
      if (COUNT_W'(k) < npop) begin
        q.new_valid[k]     = 1'b1;
        q.new_ALUOp[k]     = mem[head + PTR_W'(k)].alu_op;
        q.new_src_reg1[k]  = mem[head + PTR_W'(k)].src_reg1;
        q.new_src_reg2[k]  = mem[head + PTR_W'(k)].src_reg2;
        q.new_use_imm[k]   = mem[head + PTR_W'(k)].use_imm;
        q.new_imm[k]       = mem[head + PTR_W'(k)].imm;
        q.new_dest_reg1[k] = mem[head + PTR_W'(k)].dest_reg1;
      end
    end
  end

  // NOTE: the entry array has no reset; occupancy is tracked by count/head/tail, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < INPUT_ROWS; i++) begin
      if (push_ok && q.in_valid[i]) begin
        mem[wr_idx[i]] <= '{alu_op:    q.in_ALUOp[i],
                            src_reg1:  q.in_src_reg1[i],
                            src_reg2:  q.in_src_reg2[i],
                            use_imm:   q.in_use_imm[i],
                            imm:       q.in_imm[i],
                            dest_reg1: q.in_dest_reg1[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PTR_W'(npop);
      tail    <= tail + PTR_W'(npush);
      count_q <= count_q + npush - npop;
    end
  end

`ifdef DISPATCH_QUEUE_STATS_EN
  logic [32:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + 33'(nvalid);

  // Counters survive flush so mispredict recovery does not hide back-pressure history.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      drop_count   <= '0;
    end else begin
      if (count_q != '0 && q.rs_free == '0 && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (q.in_valid != '0 && !q.in_ready)
        drop_count <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue: reset, push/pop, compaction,
// back-pressure, pointer wrap, flush and back-to-back streaming.
module tb_dispatch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   passed = 0;
  int   total  = 0;

`ifdef DISPATCH_QUEUE_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] drop_count;
`endif

  dispatch_queue_if #(.SIZE(32), .REG_NUM(8), .ALUOP_BITS(3), .INPUT_ROWS(2), .DEPTH(8)) bus ();

  dispatch_queue #(.SIZE(32), .REG_NUM(8), .ALUOP_BITS(3), .INPUT_ROWS(2), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
`ifdef DISPATCH_QUEUE_STATS_EN
    .stall_cycles (stall_cycles),
    .drop_count   (drop_count),
`endif
    .q            (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.in_valid     = '0;
    bus.in_ALUOp     = '0;
    bus.in_src_reg1  = '0;
    bus.in_src_reg2  = '0;
    bus.in_use_imm   = '0;
    bus.in_imm       = '0;
    bus.in_dest_reg1 = '0;
    bus.rs_free      = '0;
    flush            = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.rs_free = 2'd2;
    #1;
    total++; if (bus.count !== 4'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else passed++;
    total++; if (bus.new_valid !== 2'b00) $display("FAIL reset_new_valid: got %b want 00", bus.new_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    total++;
    if (bus.new_ALUOp !== '0 || bus.new_imm !== '0 || bus.new_dest_reg1 !== '0 || bus.new_src_reg1 !== '0 ||
        bus.new_src_reg2 !== '0 || bus.new_use_imm !== '0)
      $display("FAIL reset_lanes: got imm=%h alu=%h want all zero", bus.new_imm, bus.new_ALUOp);
    else passed++;
`ifdef DISPATCH_QUEUE_STATS_EN
    total++; if (stall_cycles !== 32'd0 || drop_count !== 32'd0)
      $display("FAIL reset_stats: got stall=%0d drop=%0d want 0 0", stall_cycles, drop_count); else passed++;
`endif
  endtask

  task automatic test_single_push();
    clear_inputs();
    bus.in_valid    = 2'b01;
    bus.in_ALUOp[0] = 3'b101;
    bus.in_imm[0]   = 32'd0;
    bus.in_ALUOp[1] = 3'b011;
    bus.in_imm[1]   = 32'hDEAD;
    bus.rs_free     = 2'd2;
    #1;
    total++; if (bus.new_valid !== 2'b00) $display("FAIL empty_no_pop: got %b want 00", bus.new_valid); else passed++;
    tick();
    clear_inputs();
    bus.rs_free = 2'd2;
    #1;
    total++; if (bus.new_valid !== 2'b01) $display("FAIL single_valid: got %b want 01", bus.new_valid); else passed++;
    total++; if (bus.new_ALUOp[0] !== 3'b101) $display("FAIL single_aluop: got %b want 101", bus.new_ALUOp[0]); else passed++;
    total++; if (bus.new_ALUOp[1] !== 3'b000 || bus.new_imm[1] !== 32'd0)
      $display("FAIL single_lane1_zero: got alu=%b imm=%h want 0 0", bus.new_ALUOp[1], bus.new_imm[1]); else passed++;
    tick();
    total++; if (bus.count !== 4'd0) $display("FAIL single_drained: got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_compaction();
    clear_inputs();
    bus.in_valid        = 2'b10;
    bus.in_dest_reg1[0] = 3'd6;
    bus.in_dest_reg1[1] = 3'd3;
    tick();
    clear_inputs();
    #1;
    total++; if (bus.count !== 4'd1) $display("FAIL compact_count: got %0d want 1", bus.count); else passed++;
    total++; if (bus.new_valid !== 2'b00) $display("FAIL compact_hold: got %b want 00", bus.new_valid); else passed++;
    bus.rs_free = 2'd1;
    #1;
    total++; if (bus.new_valid !== 2'b01) $display("FAIL compact_valid: got %b want 01", bus.new_valid); else passed++;
    total++; if (bus.new_dest_reg1[0] !== 3'd3) $display("FAIL compact_dest: got %0d want 3", bus.new_dest_reg1[0]); else passed++;
    tick();
    total++; if (bus.count !== 4'd0) $display("FAIL compact_drained: got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_fill_backpressure();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      bus.in_valid  = 2'b11;
      bus.in_imm[0] = 32'(100 + 2 * c);
      bus.in_imm[1] = 32'(101 + 2 * c);
      #1;
      if (c == 3) begin
        total++; if (bus.in_ready !== 1'b1) $display("FAIL ready_at_6: got %b want 1", bus.in_ready); else passed++;
      end
      tick();
    end
    total++; if (bus.count !== 4'd8) $display("FAIL full_count: got %0d want 8", bus.count); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.in_ready); else passed++;
    bus.in_imm[0] = 32'd200;
    bus.in_imm[1] = 32'd201;
    tick();
    total++; if (bus.count !== 4'd8) $display("FAIL drop_count_kept: got %0d want 8", bus.count); else passed++;
`ifdef DISPATCH_QUEUE_STATS_EN
    total++; if (drop_count !== 32'd2) $display("FAIL drop_stat: got %0d want 2", drop_count); else passed++;
    total++; if (stall_cycles !== 32'd4) $display("FAIL stall_stat: got %0d want 4", stall_cycles); else passed++;
`endif
    clear_inputs();
    bus.rs_free = 2'd2;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (bus.new_valid !== 2'b11 || bus.new_imm[0] !== 32'(100 + 2 * c) || bus.new_imm[1] !== 32'(101 + 2 * c))
        $display("FAIL drain_order_%0d: got v=%b imm=%0d,%0d want 11 %0d,%0d", c, bus.new_valid,
                 bus.new_imm[0], bus.new_imm[1], 100 + 2 * c, 101 + 2 * c);
      else passed++;
      tick();
    end
    total++; if (bus.count !== 4'd0) $display("FAIL drain_empty: got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_wrap();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus.in_valid  = 2'b01;
      bus.in_imm[0] = 32'(c + 1);
      tick();
    end
    clear_inputs();
    total++; if (bus.count !== 4'd7 || bus.in_ready !== 1'b0)
      $display("FAIL wrap_prefill: got count=%0d ready=%b want 7 0", bus.count, bus.in_ready); else passed++;
    bus.rs_free = 2'd2;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (bus.new_imm[0] !== 32'(2 * c + 1))
        $display("FAIL wrap_pop_%0d: got %0d want %0d", c, bus.new_imm[0], 2 * c + 1); else passed++;
      if (c == 3) begin
        total++; if (bus.new_valid !== 2'b01) $display("FAIL wrap_last_single: got %b want 01", bus.new_valid); else passed++;
      end
      tick();
    end
    clear_inputs();
    bus.in_valid  = 2'b11;
    bus.in_imm[0] = 32'd10;
    bus.in_imm[1] = 32'd11;
    tick();
    clear_inputs();
    bus.rs_free = 2'd2;
    #1;
    total++;
    if (bus.new_valid !== 2'b11 || bus.new_imm[0] !== 32'd10 || bus.new_imm[1] !== 32'd11)
      $display("FAIL wrap_straddle: got v=%b imm=%0d,%0d want 11 10,11", bus.new_valid, bus.new_imm[0], bus.new_imm[1]);
    else passed++;
    tick();
    total++; if (bus.count !== 4'd0) $display("FAIL wrap_empty: got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_flush();
    clear_inputs();
    for (int c = 0; c < 2; c++) begin
      bus.in_valid  = 2'b11;
      bus.in_imm[0] = 32'(40 + c);
      bus.in_imm[1] = 32'(50 + c);
      tick();
    end
    total++; if (bus.count !== 4'd4) $display("FAIL flush_prefill: got %0d want 4", bus.count); else passed++;
    flush        = 1'b1;
    bus.in_valid = 2'b11;
    bus.rs_free  = 2'd2;
    #1;
    total++; if (bus.new_valid !== 2'b11) $display("FAIL flush_same_cycle_valid: got %b want 11", bus.new_valid); else passed++;
    tick();
    clear_inputs();
    #1;
    total++; if (bus.count !== 4'd0 || bus.new_valid !== 2'b00 || bus.in_ready !== 1'b1)
      $display("FAIL flush_cleared: got count=%0d v=%b ready=%b want 0 00 1", bus.count, bus.new_valid, bus.in_ready);
    else passed++;
    bus.in_valid  = 2'b01;
    bus.in_imm[0] = 32'd55;
    tick();
    clear_inputs();
    bus.rs_free = 2'd2;
    #1;
    total++; if (bus.new_valid !== 2'b01 || bus.new_imm[0] !== 32'd55)
      $display("FAIL flush_fresh_entry: got v=%b imm=%0d want 01 55", bus.new_valid, bus.new_imm[0]); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    bus.rs_free = 2'd2;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid  = 2'b11;
      bus.in_imm[0] = 32'(20 + 2 * c);
      bus.in_imm[1] = 32'(21 + 2 * c);
      #1;
      if (c > 0) begin
        total++;
        if (bus.count !== 4'd2 || bus.new_imm[0] !== 32'(18 + 2 * c) || bus.new_imm[1] !== 32'(19 + 2 * c))
          $display("FAIL b2b_%0d: got count=%0d imm=%0d,%0d want 2 %0d,%0d", c, bus.count,
                   bus.new_imm[0], bus.new_imm[1], 18 + 2 * c, 19 + 2 * c);
        else passed++;
      end
      tick();
    end
    bus.in_valid = 2'b00;
    tick();
    total++; if (bus.count !== 4'd0) $display("FAIL b2b_drained: got %0d want 0", bus.count); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_compaction();
    test_fill_backpressure();
    test_wrap();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
